// File: rtl/data_memory_ctrl.sv
// RV32 MEM-stage data memory: valid/ready request port, optional wait states, one-cycle response.
// Handles byte-lane stores, load sign/zero extension and misalignment/range/illegal-op faults.
module data_memory_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [3:0]  waitCnt;
  logic        lWrite;
  logic [2:0]  lFunct3;
  logic [31:0] lAddr, lWdata;

  logic [3:0][7:0] mem [DEPTH_WORDS];

  // With no wait states the access happens on the accept edge, so decode the live inputs then.
  logic        curWrite;
  logic [2:0]  curFunct3;
  logic [31:0] curAddr, curWdata;
  always_comb begin
    curWrite  = lWrite;
    curFunct3 = lFunct3;
    curAddr   = lAddr;
    curWdata  = lWdata;
    if (state == S_IDLE) begin
      curWrite  = req_write;
      curFunct3 = req_funct3;
      curAddr   = req_addr;
      curWdata  = req_wdata;
    end
  end

  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          outOfRange, badOp, misaligned, accErr, access, accept;
  logic          unusedOffsetBits;

  assign offset     = curAddr - BASE_ADDR;
  assign idx        = offset[AW+1:2];
  // Explicit addr < BASE_ADDR test: the subtraction wraps, so the index alone is not enough.
  assign outOfRange = (curAddr < BASE_ADDR) || ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS));
  assign badOp      = (curFunct3 == 3'b011) || (curFunct3 == 3'b110) || (curFunct3 == 3'b111) ||
                      (curWrite && curFunct3[2]);
  assign misaligned = ((curFunct3[1:0] == 2'b01) && curAddr[0]) ||
                      ((curFunct3[1:0] == 2'b10) && (curAddr[1:0] != 2'b00));
  assign accErr     = badOp || misaligned || outOfRange;
  assign accept     = (state == S_IDLE) && req_valid && req_ready;
  assign access     = (accept && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (waitCnt == 4'd0));
  assign unusedOffsetBits = ^offset[1:0];

  logic [3:0]      byteEn;
  logic [3:0][7:0] laneData;
  always_comb begin
    byteEn   = 4'b0000;
    laneData = {4{curWdata[7:0]}};
    case (curFunct3[1:0])
      2'b00: byteEn[curAddr[1:0]] = 1'b1;
      2'b01: begin
        byteEn   = curAddr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{curWdata[15:0]}};
      end
      default: begin
        byteEn   = 4'b1111;
        laneData = curWdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (access && curWrite && !accErr)
      for (int b = 0; b < 4; b++)
        if (byteEn[b]) mem[idx][b] <= laneData[b];
  end

  logic [31:0] word, shifted, loadVal;
  logic [15:0] halfV;
  always_comb begin
    word    = mem[idx];
    shifted = word >> {curAddr[1:0], 3'b000};
    halfV   = curAddr[1] ? word[31:16] : word[15:0];
    case (curFunct3)
      3'b000:  loadVal = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  loadVal = {24'h0, shifted[7:0]};
      3'b001:  loadVal = {{16{halfV[15]}}, halfV};
      3'b101:  loadVal = {16'h0, halfV};
      3'b010:  loadVal = word;
      default: loadVal = 32'h0;
    endcase
    if (curWrite || accErr) loadVal = 32'h0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      waitCnt   <= 4'd0;
      lWrite    <= 1'b0;
      lFunct3   <= 3'b000;
      lAddr     <= 32'h0;
      lWdata    <= 32'h0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          lWrite    <= req_write;
          lFunct3   <= req_funct3;
          lAddr     <= req_addr;
          lWdata    <= req_wdata;
          req_ready <= 1'b0;
          if (WAIT_CYCLES > 0) begin
            state   <= S_WAIT;
            waitCnt <= 4'(WAIT_CYCLES - 1);
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= loadVal;
            rsp_err   <= accErr;
          end
        end
        S_WAIT: begin
          if (waitCnt == 4'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= loadVal;
            rsp_err   <= accErr;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'h0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end
endmodule
